// File: rtl/array_bubble_sort_pkg.sv
// array_bubble_sort_pkg
// Shared definitions for the in-place bubble-sort engine:
//   - default data width and swap-counter width
//   - register-file address width / depth (32 entries, 5-bit wrapping index)
//   - FSM state encoding, also exported on the engine's debug state output
package array_bubble_sort_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 9;   // 465 swaps for a reversed 31-element array
  localparam int ADDR_W    = 5;
  localparam int DEPTH     = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    COMPARE  = 3'd2,
    SWAP_LO  = 3'd3,
    SWAP_HI  = 3'd4,
    PASS_END = 3'd5,
    DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/array_bubble_sort_regfile.sv
// sort_regfile
// 32 x WIDTH storage for the sort engine. Contents are deliberately not reset.
// Ports:
//   clock                 rising-edge clock
//   busy                  selects the write source: engine when 1, external port when 0
//   eng_we/addr/wdata     engine write port
//   ext_we/addr/wdata     external write port
//   rd_addr_a/rd_data_a   engine read port (lower element of the pair)
//   rd_addr_b/rd_data_b   engine read port (upper element of the pair)
//   ext_addr/ext_rdata    external asynchronous read port
// Reads are asynchronous, so a read of an address written on the same edge
// returns the value held before that edge.
module sort_regfile
  import array_bubble_sort_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clock,
  input  logic              busy,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [WIDTH-1:0]  eng_wdata,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [WIDTH-1:0]  ext_wdata,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic [WIDTH-1:0]  ext_rdata
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;

  // While a sort runs the engine owns the single write port; the external
  // port is locked out entirely.
  always_comb begin
    we    = ext_we;
    waddr = ext_addr;
    wdata = ext_wdata;
    if (busy) begin
      we    = eng_we;
      waddr = eng_addr;
      wdata = eng_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
  assign ext_rdata = mem[ext_addr];

endmodule

// File: rtl/array_bubble_sort.sv
// array_bubble_sort
// In-place bubble sort of `length` consecutive words of an internal 32-entry
// register file, starting at index `array`, into unsigned ascending order.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   go                    start request, accepted only in IDLE or DONE
//   array, length         base index / element count, captured on accepted go
//   ext_we/addr/wdata     external write port (ignored while busy)
//   ext_rdata             combinational read of r[ext_addr]
//   busy                  sort in progress (INIT .. PASS_END)
//   done                  last sort finished; held until next accepted go
//   swap_count            swaps performed by the current/last sort
//   dbg_state             current FSM state
// Start/finish handshake: go is a level request that is accepted on any edge
// where the engine is in IDLE or DONE; from the next cycle busy is high and
// done low, and done rises (with busy falling) in the cycle the result is
// complete. go while busy is dropped, not queued.
// Indices wrap modulo 32, so a run may straddle r31 -> r0.
module array_bubble_sort
  import array_bubble_sort_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] array,
  input  logic [ADDR_W-1:0] length,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [WIDTH-1:0]  ext_wdata,
  output logic [WIDTH-1:0]  ext_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  swap_count,
  output state_t            dbg_state
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] base, len, last, k;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              swapped;
  logic [CNT_W-1:0]  swap_q;

  logic [ADDR_W-1:0] addr_lo, addr_hi;
  logic [WIDTH-1:0]  rd_a, rd_b;
  logic              at_last;
  logic              need_swap;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [WIDTH-1:0]  eng_wdata;

  // 5-bit adds wrap naturally, giving the modulo-32 addressing.
  assign addr_lo   = base + k;
  assign addr_hi   = addr_lo + ADDR_W'(1);
  assign at_last   = (k + ADDR_W'(1)) == last;
  // Strictly greater: equal neighbours stay put, keeping the sort stable.
  assign need_swap = rd_a > rd_b;

  sort_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clock     (clock),
    .busy      (busy),
    .eng_we    (eng_we),
    .eng_addr  (eng_addr),
    .eng_wdata (eng_wdata),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .rd_addr_a (addr_lo),
    .rd_data_a (rd_a),
    .rd_addr_b (addr_hi),
    .rd_data_b (rd_b),
    .ext_rdata (ext_rdata)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and engine write port.
  always_comb begin
    state_next = state;
    eng_we     = 1'b0;
    eng_addr   = addr_lo;
    eng_wdata  = b_q;
    case (state)
      IDLE, DONE: begin
        if (go) state_next = INIT;
      end
      INIT: begin
        state_next = (len < ADDR_W'(2)) ? DONE : COMPARE;
      end
      COMPARE: begin
        if (need_swap)    state_next = SWAP_LO;
        else if (at_last) state_next = PASS_END;
      end
      SWAP_LO: begin
        eng_we     = 1'b1;
        state_next = SWAP_HI;
      end
      SWAP_HI: begin
        // The latched copy of a is used because r[base+k] now holds b.
        eng_we     = 1'b1;
        eng_addr   = addr_hi;
        eng_wdata  = a_q;
        state_next = at_last ? PASS_END : COMPARE;
      end
      PASS_END: begin
        // A clean pass, or a pass that only covered one pair, ends the sort.
        state_next = (!swapped || last == ADDR_W'(1)) ? DONE : COMPARE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: captured operands, pass bounds, pair index and swap counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base    <= '0;
      len     <= '0;
      last    <= '0;
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      swapped <= 1'b0;
      swap_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            base   <= array;
            len    <= length;
            swap_q <= '0;
          end
        end
        INIT: begin
          last    <= len - ADDR_W'(1);
          k       <= '0;
          swapped <= 1'b0;
        end
        COMPARE: begin
          if (need_swap) begin
            a_q <= rd_a;
            b_q <= rd_b;
          end else if (!at_last) begin
            k <= k + ADDR_W'(1);
          end
        end
        SWAP_HI: begin
          swap_q  <= swap_q + CNT_W'(1);
          swapped <= 1'b1;
          if (!at_last) k <= k + ADDR_W'(1);
        end
        PASS_END: begin
          // Harmless when the sort is finishing; only used on another pass.
          last    <= last - ADDR_W'(1);
          k       <= '0;
          swapped <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign swap_count = swap_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_array_bubble_sort.sv
// tb_array_bubble_sort
// Bench for array_bubble_sort: directed cases with hand-computed results plus
// randomized sorts checked against a behavioural model of the register file.
module tb_array_bubble_sort;
  import array_bubble_sort_pkg::*;

  localparam int W  = 32;
  localparam int CW = 9;

  // ---------------- clock / reset / DUT ----------------
  logic          clock = 1'b0;
  logic          reset;
  logic          go;
  logic [4:0]    array, length, ext_addr;
  logic          ext_we;
  logic [W-1:0]  ext_wdata, ext_rdata;
  logic          busy, done;
  logic [CW-1:0] swap_count;
  state_t        dbg_state;

  always #5 clock = ~clock;

  array_bubble_sort #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .array      (array),
    .length     (length),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_rdata  (ext_rdata),
    .busy       (busy),
    .done       (done),
    .swap_count (swap_count),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t       ph = M_IDLE;
  logic [W-1:0]  mem [32];
  bit            known [32];
  logic [W-1:0]  pv [32];
  int            pred_cyc, pred_sw, remain, m_len;
  logic [4:0]    m_base;
  logic [CW-1:0] exp_swap = '0;

  // Sorted result, swap total and edges from go acceptance to done.
  function automatic void predict(input logic [4:0] b, input int n);
    logic [W-1:0] t;
    int  lst;
    bit  sw, more;
    for (int i = 0; i < n; i++) pv[i] = mem[b + 5'(i)];
    pred_cyc = 1;
    pred_sw  = 0;
    if (n >= 2) begin
      lst  = n - 1;
      more = 1;
      while (more) begin
        sw = 0;
        for (int j = 0; j < lst; j++) begin
          pred_cyc++;
          if (pv[j] > pv[j+1]) begin
            t = pv[j]; pv[j] = pv[j+1]; pv[j+1] = t;
            pred_cyc += 2;
            pred_sw++;
            sw = 1;
          end
        end
        pred_cyc++;
        if (!sw || lst == 1) more = 0;
        else lst--;
      end
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    logic [4:0] ix;
    if (reset) begin
      if (ph == M_BUSY)
        for (int i = 0; i < m_len; i++) begin ix = m_base + 5'(i); known[ix] = 0; end
      ph       = M_IDLE;
      exp_swap = '0;
    end else if (ph == M_BUSY) begin
      remain--;
      if (remain == 0) begin
        for (int i = 0; i < m_len; i++) begin ix = m_base + 5'(i); mem[ix] = pv[i]; end
        exp_swap = CW'(pred_sw);
        ph       = M_DONE;
      end
    end else begin
      if (ext_we) begin mem[ext_addr] = ext_wdata; known[ext_addr] = 1; end
      if (go) begin
        m_base = array;
        m_len  = int'(length);
        predict(array, m_len);
        remain   = pred_cyc;
        exp_swap = '0;
        ph       = M_BUSY;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clock) begin
    #1;
    check("busy", busy, ph == M_BUSY);
    check("done", done, ph == M_DONE);
    if (ph != M_BUSY) begin
      check("swap_count", swap_count, exp_swap);
      if (known[ext_addr]) check("ext_rdata", ext_rdata, mem[ext_addr]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [4:0] a, input logic [W-1:0] d);
    @(negedge clock);
    ext_we = 1; ext_addr = a; ext_wdata = d;
    @(negedge clock);
    ext_we = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [W-1:0] e, input string nm);
    @(negedge clock);
    ext_addr = a;
    @(posedge clock);
    #1;
    check(nm, ext_rdata, e);
  endtask

  task automatic start(input logic [4:0] b, input logic [4:0] n);
    @(negedge clock);
    go = 1; array = b; length = n;
    @(negedge clock);
    go = 0;
  endtask

  // cyc = number of clock edges after the go edge until done is seen.
  task automatic wait_done(input int budget, input bit inject, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (inject && cyc == 2) begin
        go = 1; ext_we = 1; ext_addr = array; ext_wdata = 32'hdead_beef;
      end else if (inject && cyc == 3) begin
        go = 0; ext_we = 0;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_done: no done within %0d cycles", cyc);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int vals [5];
    logic [4:0] rb, rl;
    int mode;

    reset = 1; go = 0; array = 0; length = 0;
    ext_we = 0; ext_addr = 0; ext_wdata = 0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_swap", swap_count, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clock);
    reset = 0;

    // Sorted: done in the 7th cycle after go (6 edges after the go edge).
    for (int i = 0; i < 32; i++) wr(5'(i), W'(i));
    start(5'd11, 5'd5);
    wait_done(100, 0, cyc);
    check("sorted_latency", cyc, 6);
    check("sorted_swaps", swap_count, 0);
    check("sorted_state", dbg_state, DONE);
    for (int i = 0; i < 5; i++) rd(5'(11 + i), W'(11 + i), "sorted_data");

    // Descending 11..7 at r7.
    for (int i = 0; i < 5; i++) wr(5'(7 + i), W'(11 - i));
    start(5'd7, 5'd5);
    wait_done(200, 0, cyc);
    check("desc_latency", cyc, 35);
    check("desc_swaps", swap_count, 10);
    for (int i = 0; i < 5; i++) rd(5'(7 + i), W'(7 + i), "desc_data");

    // Partially sorted with a duplicate.
    vals = '{1, 2, 3, 2, 5};
    for (int i = 0; i < 5; i++) wr(5'(2 + i), W'(vals[i]));
    start(5'd2, 5'd5);
    wait_done(200, 0, cyc);
    check("part_swaps", swap_count, 1);
    vals = '{1, 2, 2, 3, 5};
    for (int i = 0; i < 5; i++) rd(5'(2 + i), W'(vals[i]), "part_data");

    // Wrap-around r30,r31,r0,r1.
    for (int i = 0; i < 4; i++) wr(5'(30 + i), W'(4 - i));
    start(5'd30, 5'd4);
    wait_done(200, 0, cyc);
    check("wrap_latency", cyc, 22);
    check("wrap_swaps", swap_count, 6);
    for (int i = 0; i < 4; i++) rd(5'(30 + i), W'(1 + i), "wrap_data");

    // Short lengths.
    start(5'd3, 5'd0);
    wait_done(20, 0, cyc);
    check("len0_latency", cyc, 1);
    check("len0_swaps", swap_count, 0);
    rd(5'd3, 2, "len0_data");
    start(5'd20, 5'd1);
    wait_done(20, 0, cyc);
    check("len1_latency", cyc, 1);
    rd(5'd20, 20, "len1_data");

    // Reset in the middle of a descending sort.
    for (int i = 0; i < 5; i++) wr(5'(7 + i), W'(11 - i));
    start(5'd7, 5'd5);
    repeat (4) @(negedge clock);
    #1 reset = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_swap", swap_count, 0);
    @(negedge clock);
    #1 reset = 0;
    for (int i = 0; i < 5; i++) wr(5'(7 + i), W'(11 - i));
    start(5'd7, 5'd5);
    wait_done(200, 0, cyc);
    check("after_rst_swaps", swap_count, 10);
    for (int i = 0; i < 5; i++) rd(5'(7 + i), W'(7 + i), "after_rst_data");

    // External write and go during a sort are ignored.
    for (int i = 0; i < 5; i++) wr(5'(7 + i), W'(11 - i));
    start(5'd7, 5'd5);
    wait_done(200, 1, cyc);
    check("prot_latency", cyc, 35);
    check("prot_swaps", swap_count, 10);
    for (int i = 0; i < 5; i++) rd(5'(7 + i), W'(7 + i), "prot_data");

    // Randomized sorts against the model.
    for (int run = 0; run < 8; run++) begin
      mode = run % 2;
      for (int i = 0; i < 32; i++)
        wr(5'(i), mode ? W'($urandom_range(0, 7)) : W'($urandom));
      rb = 5'($urandom_range(0, 31));
      rl = (run == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      start(rb, rl);
      wait_done(4000, 0, cyc);
      check("rand_latency", cyc, pred_cyc);
      check("rand_swaps", swap_count, CW'(pred_sw));
      for (int i = 0; i < 32; i++) rd(5'(i), mem[i], "rand_data");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
